// File: rtl/pipe_ctrl_unit.sv
// Decode-stage control unit: combinational RV32I decode plus an IDLE/STALL/FLUSH FSM
// for control-redirect bubbles. Define LOAD_USE_STALL_EN to build in load-use stalling.
module pipe_ctrl_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       BrEq_i,
    input  logic       BrLT_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memr_i,
    output logic [2:0] ImmSel_o,
    output logic [3:0] ALUSel_o,
    output logic [1:0] PCSel_o,
    output logic       BrUn_o,
    output logic       ASel_o,
    output logic       BSel_o,
    output logic       MemR_o,
    output logic       MemW_o,
    output logic       RegWEn_o,
    output logic [1:0] WBSel_o,
    output logic       insert_nop_flag_o,
    output logic       stall_o,
    output logic       illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD_I = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I   = 3'd0;
    localparam logic [2:0] IMM_S   = 3'd1;
    localparam logic [2:0] IMM_B   = 3'd2;
    localparam logic [2:0] IMM_U   = 3'd3;
    localparam logic [2:0] IMM_J   = 3'd4;
    localparam logic [2:0] IMM_NOP = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    typedef struct packed {
        logic [1:0] pcsel;
        logic [2:0] immsel;
        logic [3:0] alusel;
        logic       brun;
        logic       asel;
        logic       bsel;
        logic       memr;
        logic       memw;
        logic       regwen;
        logic [1:0] wbsel;
    } ctl_t;

    localparam ctl_t NOP_CTL = '{pcsel: 2'd0, immsel: IMM_NOP, alusel: ALU_NOP, brun: 1'b0,
                                 asel: 1'b0, bsel: 1'b0, memr: 1'b0, memw: 1'b0,
                                 regwen: 1'b0, wbsel: 2'd1};

    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    ctl_t             dec_ctl, out_ctl;
    logic             dec_illegal, dec_redirect, br_taken, hazard;
    logic             nop_c, illegal_c;

    // funct3 to ALU op; alt selects sub/sra
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_op = ALU_SLL;
            3'd2:    alu_op = ALU_SLT;
            3'd3:    alu_op = ALU_SLTU;
            3'd4:    alu_op = ALU_XOR;
            3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        case (funct3_i)
            3'd0:    br_taken = BrEq_i;
            3'd1:    br_taken = !BrEq_i;
            3'd4,
            3'd6:    br_taken = BrLT_i;
            default: br_taken = !BrLT_i;
        endcase
    end

    always_comb begin
        dec_ctl      = NOP_CTL;
        dec_illegal  = 1'b0;
        dec_redirect = 1'b0;
        case (opcode_i)
            OP_R: begin
                dec_illegal = !((funct7_i == 7'h00) ||
                                (funct7_i == 7'h20 && (funct3_i == 3'd0 || funct3_i == 3'd5)));
                dec_ctl.alusel = alu_op(funct3_i, funct7_i[5]);
                dec_ctl.regwen = 1'b1;
            end
            OP_IMM_I: begin
                if (funct3_i == 3'd1)
                    dec_illegal = (funct7_i != 7'h00);
                else if (funct3_i == 3'd5)
                    dec_illegal = !(funct7_i == 7'h00 || funct7_i == 7'h20);
                dec_ctl.immsel = IMM_I;
                dec_ctl.alusel = alu_op(funct3_i, (funct3_i == 3'd5) && funct7_i[5]);
                dec_ctl.bsel   = 1'b1;
                dec_ctl.regwen = 1'b1;
            end
            OP_LOAD_I: begin
                dec_illegal    = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
                dec_ctl.immsel = IMM_I;
                dec_ctl.alusel = ALU_ADD;
                dec_ctl.bsel   = 1'b1;
                dec_ctl.memr   = 1'b1;
                dec_ctl.regwen = 1'b1;
                dec_ctl.wbsel  = 2'd0;
            end
            OP_S: begin
                dec_illegal    = (funct3_i > 3'd2);
                dec_ctl.immsel = IMM_S;
                dec_ctl.alusel = ALU_ADD;
                dec_ctl.bsel   = 1'b1;
                dec_ctl.memw   = 1'b1;
            end
            OP_B: begin
                dec_illegal    = (funct3_i == 3'd2) || (funct3_i == 3'd3);
                dec_ctl.immsel = IMM_B;
                dec_ctl.alusel = ALU_ADD;
                dec_ctl.asel   = 1'b1;
                dec_ctl.bsel   = 1'b1;
                dec_ctl.brun   = (funct3_i == 3'd6) || (funct3_i == 3'd7);
                dec_ctl.pcsel  = br_taken ? 2'd1 : 2'd0;
                dec_redirect   = br_taken;
            end
            OP_JALR: begin
                dec_illegal    = (funct3_i != 3'd0);
                dec_ctl.immsel = IMM_I;
                dec_ctl.alusel = ALU_ADD;
                dec_ctl.bsel   = 1'b1;
                dec_ctl.regwen = 1'b1;
                dec_ctl.wbsel  = 2'd2;
                dec_ctl.pcsel  = 2'd2;
                dec_redirect   = 1'b1;
            end
            OP_J: begin
                dec_ctl.immsel = IMM_J;
                dec_ctl.alusel = ALU_ADD;
                dec_ctl.asel   = 1'b1;
                dec_ctl.bsel   = 1'b1;
                dec_ctl.regwen = 1'b1;
                dec_ctl.wbsel  = 2'd2;
                dec_ctl.pcsel  = 2'd1;
                dec_redirect   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_ctl.immsel = IMM_U;
                dec_ctl.alusel = (opcode_i == OP_LUI) ? ALU_LUI : ALU_ADD;
                dec_ctl.asel   = (opcode_i == OP_AUIPC);
                dec_ctl.bsel   = 1'b1;
                dec_ctl.regwen = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // an undecodable instruction must not leak partial controls or redirect
        if (dec_illegal) begin
            dec_ctl      = NOP_CTL;
            dec_redirect = 1'b0;
        end
    end

`ifdef LOAD_USE_STALL_EN
    logic uses_rs2;
    assign uses_rs2 = (opcode_i == OP_R) || (opcode_i == OP_S) || (opcode_i == OP_B);
    assign hazard   = ex_memr_i && (ex_rd_i != 5'd0) && !dec_illegal &&
                      ((ex_rd_i == rs1_i) || ((ex_rd_i == rs2_i) && uses_rs2));
    assign stall_o  = rst_n && (state_reg == IDLE) && hazard;
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{rs1_i, rs2_i, ex_rd_i, ex_memr_i};
    assign hazard  = 1'b0;
    assign stall_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (hazard) begin
                    state_next = STALL;
                end else if (dec_redirect) begin
                    cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
                    state_next = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
                end
            end
`ifdef LOAD_USE_STALL_EN
            STALL: begin
                state_next = IDLE;
                if (dec_redirect) begin
                    cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
                    state_next = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
                end
            end
`endif
            FLUSH: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // reset gates the outputs combinationally so they read NOP while rst_n is low
    always_comb begin
        out_ctl   = NOP_CTL;
        nop_c     = 1'b0;
        illegal_c = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (!hazard) begin
                        out_ctl   = dec_ctl;
                        nop_c     = dec_redirect;
                        illegal_c = dec_illegal;
                    end
                end
                FLUSH: nop_c = 1'b1;
                default: begin
                    out_ctl   = dec_ctl;
                    nop_c     = dec_redirect;
                    illegal_c = dec_illegal;
                end
            endcase
        end
    end

    assign PCSel_o           = out_ctl.pcsel;
    assign ImmSel_o          = out_ctl.immsel;
    assign ALUSel_o          = out_ctl.alusel;
    assign BrUn_o            = out_ctl.brun;
    assign ASel_o            = out_ctl.asel;
    assign BSel_o            = out_ctl.bsel;
    assign MemR_o            = out_ctl.memr;
    assign MemW_o            = out_ctl.memw;
    assign RegWEn_o          = out_ctl.regwen;
    assign WBSel_o           = out_ctl.wbsel;
    assign insert_nop_flag_o = nop_c;
    assign illegal_o         = illegal_c;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: two instances (FLUSH_CYCLES 2 and 4) driven in lockstep.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       breq, brlt, ex_memr;
    logic [4:0] rs1, rs2, ex_rd;

    logic [2:0] imm2, imm4;
    logic [3:0] alu2, alu4;
    logic [1:0] pc2, pc4, wb2, wb4;
    logic       brun2, asel2, bsel2, memr2, memw2, rwe2, nop2, stall2, ill2;
    logic       brun4, asel4, bsel4, memr4, memw4, rwe4, nop4, stall4, ill4;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .BrEq_i(breq), .BrLT_i(brlt), .rs1_i(rs1), .rs2_i(rs2), .ex_rd_i(ex_rd),
        .ex_memr_i(ex_memr), .ImmSel_o(imm2), .ALUSel_o(alu2), .PCSel_o(pc2), .BrUn_o(brun2),
        .ASel_o(asel2), .BSel_o(bsel2), .MemR_o(memr2), .MemW_o(memw2), .RegWEn_o(rwe2),
        .WBSel_o(wb2), .insert_nop_flag_o(nop2), .stall_o(stall2), .illegal_o(ill2));

    pipe_ctrl_unit #(.FLUSH_CYCLES(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .BrEq_i(breq), .BrLT_i(brlt), .rs1_i(rs1), .rs2_i(rs2), .ex_rd_i(ex_rd),
        .ex_memr_i(ex_memr), .ImmSel_o(imm4), .ALUSel_o(alu4), .PCSel_o(pc4), .BrUn_o(brun4),
        .ASel_o(asel4), .BSel_o(bsel4), .MemR_o(memr4), .MemW_o(memw4), .RegWEn_o(rwe4),
        .WBSel_o(wb4), .insert_nop_flag_o(nop4), .stall_o(stall4), .illegal_o(ill4));

    // {pcsel, immsel, alusel, brun, asel, bsel, memr, memw, regwen, wbsel, nop, stall, illegal}
    logic [19:0] got2, got4;
    assign got2 = {pc2, imm2, alu2, brun2, asel2, bsel2, memr2, memw2, rwe2, wb2, nop2, stall2, ill2};
    assign got4 = {pc4, imm4, alu4, brun4, asel4, bsel4, memr4, memw4, rwe4, wb4, nop4, stall4, ill4};

    function automatic logic [19:0] w(input logic [1:0] pc, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic brun, input logic as,
                                      input logic bs, input logic mr, input logic mw,
                                      input logic we, input logic [1:0] wb, input logic nop,
                                      input logic st, input logic il);
        return {pc, imm, alu, brun, as, bs, mr, mw, we, wb, nop, st, il};
    endfunction

    localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011, OP_JALR = 7'b1100111, OP_J = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_BAD = 7'h7F;

    logic [19:0] NOPW, NOPF, ADDW, SUBW, JALW, BTKN, BNTK, BLTU, ILLW, LWW, SWW, JALRW, LUIW, STLW;

    typedef struct {
        logic [19:0] e2;
        logic [19:0] e4;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic step(input string tag, input logic rst, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic eq,
                        input logic lt, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] erd, input logic emr,
                        input logic [19:0] x2, input logic [19:0] x4);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; opcode = op; funct3 = f3; funct7 = f7; breq = eq; brlt = lt;
        rs1 = r1; rs2 = r2; ex_rd = erd; ex_memr = emr;
        e.e2 = x2; e.e4 = x4; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic ins(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic eq, input logic lt,
                       input logic [19:0] x2, input logic [19:0] x4);
        step(tag, 1'b1, op, f3, f7, eq, lt, 5'd1, 5'd2, 5'd0, 1'b0, x2, x4);
    endtask

    task automatic add_op(input string tag, input logic [19:0] x2, input logic [19:0] x4);
        ins(tag, OP_R, 3'd0, 7'h00, 1'b0, 1'b0, x2, x4);
    endtask

    // monitor: one scoreboard entry per cycle, sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                tests_run++;
                if (got2 !== e.e2) begin
                    tests_failed++;
                    $display("FAIL %s fc2: got %h expected %h", e.tag, got2, e.e2);
                end
                tests_run++;
                if (got4 !== e.e4) begin
                    tests_failed++;
                    $display("FAIL %s fc4: got %h expected %h", e.tag, got4, e.e4);
                end
                $display("[TB] %-10s fc2=%h fc4=%h", e.tag, got2, got4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        NOPW  = w(0, 7, 15, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        NOPF  = w(0, 7, 15, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        ADDW  = w(0, 7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        SUBW  = w(0, 7, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        JALW  = w(1, 4, 0, 0, 1, 1, 0, 0, 1, 2, 1, 0, 0);
        BTKN  = w(1, 2, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        BNTK  = w(0, 2, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        BLTU  = w(1, 2, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        ILLW  = w(0, 7, 15, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        LWW   = w(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        SWW   = w(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        JALRW = w(2, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 0, 0);
        LUIW  = w(0, 3, 10, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        STLW  = w(0, 7, 15, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

        rst_n = 1'b0; opcode = OP_R; funct3 = 3'd0; funct7 = 7'h00; breq = 1'b0;
        brlt = 1'b0; rs1 = 5'd1; rs2 = 5'd2; ex_rd = 5'd0; ex_memr = 1'b0;

        step("reset", 1'b0, OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, NOPW, NOPW);
        add_op("add", ADDW, ADDW);

        ins("jal", OP_J, 3'd0, 7'h00, 1'b0, 1'b0, JALW, JALW);
        add_op("jal_f1", NOPF, NOPF);
        add_op("jal_f2", ADDW, NOPF);
        add_op("jal_f3", ADDW, NOPF);
        add_op("jal_end", ADDW, ADDW);

        ins("beq_t", OP_B, 3'd0, 7'h00, 1'b1, 1'b0, BTKN, BTKN);
        add_op("beq_f1", NOPF, NOPF);
        add_op("beq_f2", ADDW, NOPF);
        add_op("beq_f3", ADDW, NOPF);
        add_op("beq_end", ADDW, ADDW);
        ins("beq_nt", OP_B, 3'd0, 7'h00, 1'b0, 1'b0, BNTK, BNTK);

        ins("bltu_t", OP_B, 3'd6, 7'h00, 1'b0, 1'b1, BLTU, BLTU);
        add_op("bltu_f1", NOPF, NOPF);
        add_op("bltu_f2", ADDW, NOPF);
        add_op("bltu_f3", ADDW, NOPF);
        add_op("bltu_end", ADDW, ADDW);

        ins("jal_rst", OP_J, 3'd0, 7'h00, 1'b0, 1'b0, JALW, JALW);
        step("mid_rst", 1'b0, OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b0, NOPW, NOPW);
        add_op("post_rst", ADDW, ADDW);
        ins("illegal", OP_BAD, 3'd0, 7'h00, 1'b0, 1'b0, ILLW, ILLW);

        ins("lw", OP_LOAD, 3'd2, 7'h00, 1'b0, 1'b0, LWW, LWW);
        ins("sw", OP_S, 3'd2, 7'h00, 1'b0, 1'b0, SWW, SWW);
        ins("jalr", OP_JALR, 3'd0, 7'h00, 1'b0, 1'b0, JALRW, JALRW);
        add_op("jalr_f1", NOPF, NOPF);
        add_op("jalr_f2", ADDW, NOPF);
        add_op("jalr_f3", ADDW, NOPF);
        add_op("jalr_end", ADDW, ADDW);
        ins("sub", OP_R, 3'd0, 7'h20, 1'b0, 1'b0, SUBW, SUBW);
        ins("bad_f7", OP_R, 3'd1, 7'h20, 1'b0, 1'b0, ILLW, ILLW);
        ins("lui", OP_LUI, 3'd0, 7'h00, 1'b0, 1'b0, LUIW, LUIW);

        ins("jal2", OP_J, 3'd0, 7'h00, 1'b0, 1'b0, JALW, JALW);
        ins("ill_flush", OP_BAD, 3'd0, 7'h00, 1'b0, 1'b0, NOPF, NOPF);
        add_op("jal2_f2", ADDW, NOPF);
        add_op("jal2_f3", ADDW, NOPF);
        add_op("jal2_end", ADDW, ADDW);

`ifdef LOAD_USE_STALL_EN
        step("lu_stall", 1'b1, OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 5'd1, 5'd5, 5'd5, 1'b1, STLW, STLW);
        step("lu_resume", 1'b1, OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 5'd1, 5'd5, 5'd5, 1'b1, ADDW, ADDW);
        step("lu_x0", 1'b1, OP_R, 3'd0, 7'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, ADDW, ADDW);
        step("bne_haz", 1'b1, OP_B, 3'd1, 7'h00, 1'b0, 1'b0, 5'd5, 5'd2, 5'd5, 1'b1, STLW, STLW);
        step("bne_stall", 1'b1, OP_B, 3'd1, 7'h00, 1'b0, 1'b0, 5'd5, 5'd2, 5'd5, 1'b1, BTKN, BTKN);
        add_op("bne_f1", NOPF, NOPF);
        add_op("bne_f2", ADDW, NOPF);
        add_op("bne_f3", ADDW, NOPF);
        add_op("bne_end", ADDW, ADDW);
`endif

        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending entries, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
